ghash_ctrl: RTL and testbench

GHASH_CTRL -- requirements
Module: ghash_ctrl

---
 rtl/ghash_ctrl.sv | 91 +++++++++
 tb/tb_ghash_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/ghash_ctrl.sv
// GHASH chaining controller: feeds X^C_i and H to an external GF(2^128)
// multiplier with fixed latency MUL_LAT and folds each product back into X.
module ghash_ctrl #(
  parameter int MUL_LAT = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         iStart,
  input  logic [127:0] iHashkey,
  input  logic [127:0] iBlk,
  input  logic         iBlkValid,
  input  logic         iLast,
  output logic         oBlkReady,
  output logic [127:0] oMulA,
  output logic [127:0] oMulB,
  input  logic [127:0] iMulResult,
  output logic [127:0] oTag,
  output logic         oTagValid,
  output logic         oBusy
);

  typedef enum logic [1:0] {IDLE, WAIT_BLK, MUL, DONE} state_t;

  localparam logic [3:0] LAT = 4'(MUL_LAT);

  state_t       state;
  logic [127:0] x;
  logic [127:0] h;
  logic [3:0]   cnt;
  logic         last;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      x         <= '0;
      h         <= '0;
      cnt       <= '0;
      last      <= 1'b0;
      oMulA     <= '0;
      oMulB     <= '0;
      oTag      <= '0;
      oTagValid <= 1'b0;
      oBlkReady <= 1'b0;
      oBusy     <= 1'b0;
    end else begin
      oTagValid <= 1'b0;
      case (state)
        IDLE: begin
          if (iStart) begin
            h         <= iHashkey;
            x         <= '0;
            state     <= WAIT_BLK;
            oBlkReady <= 1'b1;
            oBusy     <= 1'b1;
          end
        end
        WAIT_BLK: begin
          if (iBlkValid) begin
            oMulA     <= x ^ iBlk;
            oMulB     <= h;
            last      <= iLast;
            cnt       <= LAT;
            state     <= MUL;
            oBlkReady <= 1'b0;
          end
        end
        MUL: begin
          cnt <= cnt - 4'd1;
          // Product is only guaranteed valid on the final MUL cycle.
          if (cnt == 4'd1) begin
            x <= iMulResult;
            if (last) begin
              state     <= DONE;
              oTag      <= iMulResult;
              oTagValid <= 1'b1;
            end else begin
              state     <= WAIT_BLK;
              oBlkReady <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          oBusy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ghash_ctrl.sv
// Directed bench for ghash_ctrl with a behavioural GCM multiplier (MUL_LAT=2).
module tb_ghash_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         iStart;
  logic [127:0] iHashkey;
  logic [127:0] iBlk;
  logic         iBlkValid;
  logic         iLast;
  logic         oBlkReady;
  logic [127:0] oMulA;
  logic [127:0] oMulB;
  logic [127:0] iMulResult;
  logic [127:0] oTag;
  logic         oTagValid;
  logic         oBusy;

  int checks = 0;
  int errors = 0;

  logic         force_en = 1'b0;
  logic [127:0] force_val = '0;

  ghash_ctrl #(.MUL_LAT(2)) dut (
    .clk(clk), .rst(rst), .iStart(iStart), .iHashkey(iHashkey),
    .iBlk(iBlk), .iBlkValid(iBlkValid), .iLast(iLast), .oBlkReady(oBlkReady),
    .oMulA(oMulA), .oMulB(oMulB), .iMulResult(iMulResult), .oTag(oTag),
    .oTagValid(oTagValid), .oBusy(oBusy)
  );

  always #5 clk = ~clk;

  // GCM bit-reflected GF(2^128) multiply.
  function automatic logic [127:0] gf_mul(input logic [127:0] a, input logic [127:0] b);
    logic [127:0] z = '0;
    logic [127:0] v = b;
    for (int i = 0; i < 128; i++) begin
      if (a[127-i]) z = z ^ v;
      v = v[0] ? ((v >> 1) ^ {8'he1, 120'h0}) : (v >> 1);
    end
    return z;
  endfunction

  // One register stage: operands registered at the acceptance edge give a
  // valid product two edges later, matching MUL_LAT=2.
  always @(posedge clk) iMulResult <= force_en ? force_val : gf_mul(oMulA, oMulB);

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  localparam logic [127:0] H1 = 128'hb83b533708bf535d0aa6e52980d53b78;
  localparam logic [127:0] H2 = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [127:0] BA = 128'h0123456789abcdef_fedcba9876543210;
  localparam logic [127:0] BB = 128'h00000000000000a0_0000000000000080;
  localparam logic [127:0] BC = 128'hdeadbeef_00000000_cafef00d_00000001;
  localparam logic [127:0] BD = 128'h80000000_00000000_00000000_00000003;
  localparam logic [127:0] BE = 128'hffffffff_ffffffff_ffffffff_ffffffff;

  logic [127:0] p1;

  initial begin
    rst = 1'b1; iStart = 1'b0; iHashkey = '0; iBlk = '0; iBlkValid = 1'b0; iLast = 1'b0;
    step(); step();
    check("rst_busy",  128'(oBusy), 128'(0));
    check("rst_ready", 128'(oBlkReady), 128'(0));
    check("rst_tagv",  128'(oTagValid), 128'(0));
    check("rst_tag",   oTag, '0);
    check("rst_mula",  oMulA, '0);
    rst = 1'b0;

    // single block
    iStart = 1'b1; iHashkey = H1; step(); iStart = 1'b0;
    check("sb_ready", 128'(oBlkReady), 128'(1));
    check("sb_busy",  128'(oBusy), 128'(1));
    iBlk = 128'h5; iBlkValid = 1'b1; iLast = 1'b1; step();
    iBlkValid = 1'b0; iLast = 1'b0;
    check("sb_mula",   oMulA, 128'h5);
    check("sb_mulb",   oMulB, H1);
    check("sb_rdy_mul", 128'(oBlkReady), 128'(0));
    check("sb_tagv_e0", 128'(oTagValid), 128'(0));
    step();
    check("sb_tagv_e1", 128'(oTagValid), 128'(0));
    check("sb_mula_hold", oMulA, 128'h5);
    step();
    check("sb_tagv_e2", 128'(oTagValid), 128'(1));
    check("sb_tag", oTag, gf_mul(128'h5, H1));
    step();
    check("sb_tagv_e3", 128'(oTagValid), 128'(0));
    check("sb_idle",    128'(oBusy), 128'(0));
    check("sb_tag_hold", oTag, gf_mul(128'h5, H1));

    // chaining with forced first product
    force_en = 1'b1; force_val = 128'h1234;
    iStart = 1'b1; step(); iStart = 1'b0;
    iBlk = 128'h5; iBlkValid = 1'b1; iLast = 1'b0; step(); iBlkValid = 1'b0;
    check("ch_mula1", oMulA, 128'h5);
    step(); step();
    check("ch_ready2", 128'(oBlkReady), 128'(1));
    check("ch_notag",  128'(oTagValid), 128'(0));
    force_en = 1'b0;
    iBlk = 128'h1; iBlkValid = 1'b1; iLast = 1'b1; step();
    iBlkValid = 1'b0; iLast = 1'b0;
    check("ch_mula2", oMulA, 128'h1235);
    step();
    check("ch_mula2_hold", oMulA, 128'h1235);
    step();
    check("ch_tagv", 128'(oTagValid), 128'(1));
    check("ch_tag",  oTag, gf_mul(128'h1235, H1));
    step();

    // backpressure: valid held high through MUL and DONE
    iStart = 1'b1; iHashkey = H1; step(); iStart = 1'b0;
    iBlk = BA; iBlkValid = 1'b1; iLast = 1'b0; step();
    check("bp_mula1", oMulA, BA);
    check("bp_rdy0",  128'(oBlkReady), 128'(0));
    step();
    check("bp_rdy1",  128'(oBlkReady), 128'(0));
    check("bp_once",  oMulA, BA);
    step();
    p1 = gf_mul(BA, H1);
    check("bp_rdy_wait", 128'(oBlkReady), 128'(1));
    check("bp_once2", oMulA, BA);
    iBlk = BB; iLast = 1'b1; step();
    check("bp_mula2", oMulA, p1 ^ BB);
    step();
    check("bp_rdy_mul2", 128'(oBlkReady), 128'(0));
    step();
    check("bp_tagv", 128'(oTagValid), 128'(1));
    check("bp_tag",  oTag, gf_mul(p1 ^ BB, H1));
    check("bp_rdy_done", 128'(oBlkReady), 128'(0));
    step();
    check("bp_idle_busy", 128'(oBusy), 128'(0));
    check("bp_idle_rdy",  128'(oBlkReady), 128'(0));
    iBlkValid = 1'b0; iLast = 1'b0;

    // iStart in WAIT_BLK ignored
    iStart = 1'b1; iHashkey = H1; step();
    iHashkey = H2; step(); iStart = 1'b0;
    check("ws_ready", 128'(oBlkReady), 128'(1));
    iBlk = BC; iBlkValid = 1'b1; iLast = 1'b1; step();
    iBlkValid = 1'b0; iLast = 1'b0;
    check("ws_mulb", oMulB, H1);
    check("ws_mula", oMulA, BC);
    step(); step();
    check("ws_tag", oTag, gf_mul(BC, H1));
    step();

    // iStart with iBlkValid in IDLE: block not taken
    iStart = 1'b1; iHashkey = H2; iBlk = BD; iBlkValid = 1'b1; iLast = 1'b1; step();
    iStart = 1'b0; iBlkValid = 1'b0;
    check("sv_ready",   128'(oBlkReady), 128'(1));
    check("sv_notaken", oMulA, BC);
    iBlkValid = 1'b1; step();
    iBlkValid = 1'b0; iLast = 1'b0;
    check("sv_mula", oMulA, BD);
    check("sv_mulb", oMulB, H2);
    step(); step();
    check("sv_tag", oTag, gf_mul(BD, H2));
    step();

    // reset during the first MUL cycle
    iStart = 1'b1; iHashkey = H2; step(); iStart = 1'b0;
    iBlk = BE; iBlkValid = 1'b1; iLast = 1'b1; step();
    iBlkValid = 1'b0; iLast = 1'b0;
    rst = 1'b1; step(); rst = 1'b0;
    check("rm_busy", 128'(oBusy), 128'(0));
    check("rm_rdy",  128'(oBlkReady), 128'(0));
    check("rm_mula", oMulA, '0);
    check("rm_mulb", oMulB, '0);
    check("rm_tag",  oTag, '0);
    check("rm_tagv", 128'(oTagValid), 128'(0));
    step();
    check("rm_tagv_later", 128'(oTagValid), 128'(0));
    check("rm_tag_later",  oTag, '0);
    iStart = 1'b1; iHashkey = H1; step(); iStart = 1'b0;
    iBlk = 128'h5; iBlkValid = 1'b1; iLast = 1'b1; step();
    iBlkValid = 1'b0; iLast = 1'b0;
    check("rm_fresh_mula", oMulA, 128'h5);
    step(); step();
    check("rm_fresh_tagv", 128'(oTagValid), 128'(1));
    check("rm_fresh_tag",  oTag, gf_mul(128'h5, H1));
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
